word_receiver: RTL
==================

# word_receiver

Parametrised serial-word assembler. It collects NUM_BYTES consecutive bytes from the upstream UART byte receiver into one word and presents it on a valid/ready output holding register. It adds selectable byte order, an inter-byte timeout that discards partial words, and overrun detection. It sits between the UART byte receiver and the command/operand decoders, and generalises the fixed 4-byte, little-endian integer receiver.

## Interface
- NUM_BYTES, 4, bytes per word; legal range 2..16.
- MSB_FIRST, 0, byte order:
  - 0: first byte lands in bits [7:0] (little-endian).
  - 1: first byte lands in the top byte.
- TIMEOUT_CYCLES, 100000, idle clk cycles allowed between bytes of one word; must be ≥1.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  byte from UART receiver.
- in_valid  in  1  one-cycle pulse; in_data is valid in that cycle.
- out_data  out  8*NUM_BYTES  assembled word (signed interpretation left to consumer).
- out_valid  out  1  word held in output register.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- busy  out  1  partial word in progress (state COLLECT).
- timeout  out  1  one-cycle pulse: partial word discarded.
- overrun  out  1  one-cycle pulse: completed word dropped because output register was full.

## Operation
- Reset values:
  - out_data=0, out_valid=0, busy=0, timeout=0, overrun=0.
  - Byte count=0, shift register=0, timeout counter=0, state=IDLE.
- States:
  - IDLE: count=0. in_valid stores the byte at position 0, sets count=1, clears the timer, and moves to COLLECT.
  - COLLECT: each in_valid stores the byte at position count, increments count, and clears the timer.
    - On the NUM_BYTES-th byte: the word completes, count returns to 0, and the state returns to IDLE.
    - With no in_valid, the timer increments.
    - When the timer reaches TIMEOUT_CYCLES: clear the shift register and count, pulse timeout, return to IDLE.
- Byte placement:
  - MSB_FIRST=0: byte k → bits [8k+7:8k].
  - MSB_FIRST=1: byte k → bits [8(NUM_BYTES-1-k)+7 : 8(NUM_BYTES-1-k)].
- Word completion, with output register free or drained this cycle (out_ready && out_valid): load out_data with the full word, including the final byte directly, and set out_valid=1.
- Word completion with out_valid=1 and out_ready=0: drop the new word, keep the old out_data, pulse overrun.
- Handshake: out_valid clears on out_valid && out_ready unless a new word loads in the same cycle. out_data is stable while out_valid=1 and out_ready=0.
- Assembly continues independently of the output register; a pending output never stalls byte collection.
- in_valid in the same cycle the timer would expire: the byte wins. It is accepted, the timer clears, and no timeout is raised.
- rst mid-word or with out_valid=1: everything returns to reset values next cycle and the pending word is lost.
- Counter widths:
  - Byte count: $clog2(NUM_BYTES)+1 bits.
  - Timer: $clog2(TIMEOUT_CYCLES+1) bits; saturates, never wraps.

## Timing
- Byte accepted in the in_valid cycle.
- out_valid rises on the clk edge after the final in_valid cycle: 1-cycle latency.
- timeout asserts on the edge where the timer equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after the last accepted byte, for one cycle.
- overrun asserts for one cycle in the completion cycle + 1.
- busy is registered and tracks state==COLLECT.
- Back-to-back in_valid on consecutive cycles is supported: one byte per clk.

## Configuration
- WORD_RECEIVER_TIMEOUT_EN defined: timeout counter and timeout output behave as above.
- Not defined:
  - No timer logic is generated.
  - The timeout port remains but is tied to 0.
  - A partial word waits indefinitely for its remaining bytes and is only cleared by rst.

## Structure
- Package word_rx_pkg holds:
  - State enum: IDLE=1'b0, COLLECT=1'b1.
  - Localparam function for byte-lane index given MSB_FIRST.
  - BYTE_W=8 constant.
- One sub-module, rx_idle_timer: saturating counter with clear, enable and expired outputs. It is instantiated only under WORD_RECEIVER_TIMEOUT_EN.

## Test plan
- NUM_BYTES=4, MSB_FIRST=0, out_ready=1: bytes 0x78,0x56,0x34,0x12 spaced 10 cycles → out_valid for 1 cycle with out_data=0x12345678; busy high from first byte to completion.
- NUM_BYTES=4, MSB_FIRST=1: same bytes → out_data=0x78563412; also 0xFF,0xFF,0xFF,0xFE → 0xFFFFFFFE (−2 signed).
- TIMEOUT_CYCLES=20: send 0xAA,0xBB then silence → timeout pulse exactly 20 cycles after 0xBB, busy=0. Then 4 new bytes 01,02,03,04 → 0x04030201, no trace of AA/BB. Also, a byte exactly on cycle 20 → no timeout.
- out_ready=0: send two full words 0x11111111 then 0x22222222 → out_data stays 0x11111111 and overrun pulses once. Raise out_ready → out_valid drops next cycle.
- out_ready pulsed in the completion cycle of word 2 while word 1 is held → word 2 loads, out_valid stays 1, no overrun.
- Assert rst after 2 of 4 bytes → all outputs 0 next cycle. Following 4 bytes assemble correctly. Repeat with NUM_BYTES=2 and 8 (back-to-back in_valid).

Source files
------------

// File: rtl/word_rx_pkg.sv
// Shared definitions for the serial-word assembler: state encoding, byte width
// and the byte-lane mapping used for both byte orders.
package word_rx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } rx_state_e;

  // Lane (byte slot within the word) that the k-th received byte occupies.
  function automatic int unsigned byte_lane(input int unsigned k,
                                            input int unsigned num_bytes,
                                            input bit          msb_first);
    return msb_first ? (num_bytes - 1 - k) : k;
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Saturating idle-cycle counter. 'expired' flags the cycle whose clock edge
// brings the count up to LIMIT, so the owner can act on that same edge.
module rx_idle_timer #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;

  assign expired = en && !clr && (count_q == CW'(LIMIT - 1));

  // Count enabled idle cycles; hold at LIMIT instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en && (count_q != CW'(LIMIT))) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/word_receiver.sv
// Serial-word assembler: gathers NUM_BYTES bytes from the UART byte receiver
// into one word and holds it in a valid/ready output register.
// Optional inter-byte timeout is built only when WORD_RECEIVER_TIMEOUT_EN is
// defined; otherwise the timeout port is tied low and partial words persist.
module word_receiver
  import word_rx_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 4,
  parameter bit          MSB_FIRST      = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BYTE_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic [BYTE_W*NUM_BYTES-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        timeout,
  output logic                        overrun
);

  localparam int unsigned WORD_W = BYTE_W * NUM_BYTES;
  localparam int unsigned CNT_W  = $clog2(NUM_BYTES) + 1;
  localparam int unsigned IDX_W  = $clog2(WORD_W);

  rx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [WORD_W-1:0]  word_full;
  logic [WORD_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic               last_byte;
  logic               word_done;
  logic               timer_expired;

  assign last_byte = (count_q == CNT_W'(NUM_BYTES - 1));

  // Shift register with the current byte merged into its lane
  always_comb begin
    word_full = shift_q;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (count_q == CNT_W'(k)) begin
        word_full[IDX_W'(BYTE_W * byte_lane(k, NUM_BYTES, MSB_FIRST)) +: BYTE_W] = in_data;
      end
    end
  end

  // Collection FSM: byte counting, completion and timeout discard
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = word_full;
          count_d = CNT_W'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          if (last_byte) begin
            word_done = 1'b1;
            shift_d   = '0;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            shift_d = word_full;
            count_d = count_q + 1'b1;
          end
        end else if (timer_expired) begin
          // An arriving byte takes priority, so expiry only matters when idle
          shift_d = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  // Output holding register: load when free or draining, otherwise flag overrun
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    overrun_d   = 1'b0;
    if (word_done) begin
      if (out_valid_d) begin
        overrun_d = 1'b1;
      end else begin
        out_data_d  = word_full;
        out_valid_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef WORD_RECEIVER_TIMEOUT_EN
  logic timer_clr;
  logic timer_en;
  logic timeout_q;

  // Timer restarts on every accepted byte and stays cleared while idle
  assign timer_clr = (state_q == IDLE) || in_valid;
  assign timer_en  = (state_q == COLLECT);

  rx_idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expired(timer_expired)
  );

  // One-cycle pulse on the edge that discards the partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timer_expired;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timer_expired      = 1'b0;
  assign timeout            = 1'b0;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == COLLECT);

endmodule
